fpu_sp_arbiter: RTL and testbench
=================================

// Module: fpu_sp_arbiter
// PURPOSE
// - Shares one fpu_sp single-precision ALU (opcodes ADD/SUB/MUL/DIV) between NREQ requesters.
// - Round-robin grant, valid/ready request and response channels per requester.
// - Holds FPU operands/opcode stable for the whole operation and waits for the FPU Ready flag
//   (timeout-protected). Returns result plus Overflow/Underflow to the granted requester only.
// PARAMETERS
// - WIDTH     32  operand/result width (IEEE-754 single)
// - NREQ      2   number of requesters (>=2)
// - MIN_WAIT  2   min WAIT cycles before fpu_ready is trusted (masks stale Ready from previous op)
// - TIMEOUT   16  WAIT cycles before op is abandoned (> MIN_WAIT)
// PORTS
// - clk            in   1           clock, rising edge
// - rst_n          in   1           async active-low reset
// - req_valid      in   NREQ        request valid, one bit per requester
// - req_ready      out  NREQ        request accepted (one-hot or zero)
// - req_a          in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
// - req_b          in   NREQ*WIDTH  operand B, same packing
// - req_op         in   NREQ*2      opcode, requester i at [i*2 +: 2]
// - rsp_valid      out  NREQ        response valid (one-hot or zero)
// - rsp_ready      in   NREQ        response accepted by requester
// - rsp_result     out  WIDTH       result, shared bus, meaningful when any rsp_valid
// - rsp_overflow   out  1           captured FPU Overflow
// - rsp_underflow  out  1           captured FPU Underflow
// - rsp_timeout    out  1           op abandoned; rsp_result=0
// - fpu_a, fpu_b   out  WIDTH       to fpu_sp A/B (registered)
// - fpu_op         out  2           to fpu_sp opCode (registered)
// - fpu_result     in   WIDTH       from fpu_sp result
// - fpu_ready      in   1           from fpu_sp Ready
// - fpu_overflow   in   1           from fpu_sp Overflow
// - fpu_underflow  in   1           from fpu_sp Underflow
// - busy           out  1           state != IDLE
// - grant_id       out  clog2(NREQ) index of current/last granted requester
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; rr pointer selects requester 0 first; wait counter 0.
//   Reset mid-op abandons the op silently (no response).
// - FSM IDLE -> WAIT -> RESP -> IDLE.
// - IDLE: winner = first i with req_valid[i], searched from (last_grant+1) mod NREQ.
//   req_ready[winner]=1 combinationally; only in IDLE.
//   Accept when valid&ready: capture a/b/op into fpu_* regs, grant_id=winner, cnt=0, go WAIT.
//   req_valid may drop before acceptance without effect. Operand changes after accept are ignored.
// - WAIT: cnt increments each cycle (saturates). fpu_* held constant.
//   If cnt>=MIN_WAIT && fpu_ready: capture result and flags, rsp_timeout=0, go RESP.
//   Else if cnt==TIMEOUT: rsp_result=0, flags=0, rsp_timeout=1, go RESP. Ready has priority on the same cycle.
// - RESP: rsp_valid[grant_id]=1, data stable until rsp_ready[grant_id]; then go IDLE and
//   last_grant=grant_id. rsp_ready of other requesters is ignored.
// - Min latency: accept edge to rsp_valid high = MIN_WAIT+1 cycles. One op in flight; no pipelining.
// - fpu_* retain last values in IDLE (no toggling). rsp_* hold until the next capture.
// - Back-to-back: a new accept is possible on the cycle after the response handshake.
// STRUCTURE
// - Package fpu_sp_pkg: OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11; state enum
//   (IDLE, WAIT, RESP); WIDTH default.
// - Sub-module rr_arbiter #(NREQ): req vector + last_grant -> one-hot grant + index, combinational.
// - Top: FSM, wait counter, operand/result registers, response steering.
// TESTING  (bench uses a behavioural fpu_sp model with settable latency L)
// - Single req0 ADD 0x40866666 (4.2) + 0x404CCCCD (3.2), L=2 -> rsp_valid[0] at accept+3,
//   rsp_result=0x40ECCCCD, flags 0.
// - req0 and req1 both valid: req1 MUL 0x42F60000*0x43CE0000 -> grants in order 0,1,0,1;
//   req1 results 0x4745F400; no requester starves.
// - Stale Ready: fpu_ready held 1 throughout, L=5 -> result captured at cnt==MIN_WAIT.
//   Bench checks arbiter timing only.
// - fpu_ready never asserted -> rsp_valid at accept+TIMEOUT+1, rsp_timeout=1, rsp_result=0.
// - rsp_ready held 0 for 7 cycles -> rsp_valid and data stable, req_ready stays 0, busy=1.
// - rst_n pulsed low during WAIT -> all outputs 0 immediately; next op responds correctly.

Source files
------------

// File: rtl/fpu_sp_pkg.sv
// fpu_sp_pkg: opcodes, FSM state type and default width
// shared by the single-precision FPU arbiter slice.
package fpu_sp_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/fpu_sp_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching upward
// from the requester after last.
module rr_arbiter
    import fpu_sp_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = IW'((int'(last) + k) % NREQ);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/fpu_sp_arbiter.sv
// fpu_sp_arbiter: shares one fpu_sp ALU between NREQ requesters
// with round-robin grant, timeout-protected wait and steered response.
module fpu_sp_arbiter
    import fpu_sp_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int NREQ     = 2,
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 16,
    localparam int IW      = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_op,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_underflow,
    output logic                  rsp_timeout,
    output logic [WIDTH-1:0]      fpu_a,
    output logic [WIDTH-1:0]      fpu_b,
    output logic [1:0]            fpu_op,
    input  logic [WIDTH-1:0]      fpu_result,
    input  logic                  fpu_ready,
    input  logic                  fpu_overflow,
    input  logic                  fpu_underflow,
    output logic                  busy,
    output logic [IW-1:0]         grant_id
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CMIN = CW'(MIN_WAIT);
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] last;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   win;
    logic            win_any;

    logic [WIDTH-1:0] a_arr  [NREQ];
    logic [WIDTH-1:0] b_arr  [NREQ];
    logic [1:0]       op_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g]  = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g]  = req_b[g*WIDTH +: WIDTH];
        assign op_arr[g] = req_op[g*2 +: 2];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req  (req_valid),
        .last (last),
        .gnt  (gnt),
        .idx  (win),
        .any  (win_any)
    );

    assign req_ready = (state == IDLE) ? gnt : '0;
    assign busy      = (state != IDLE);

    // stale Ready from the previous op is masked until cnt reaches CMIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            last          <= IW'(NREQ - 1);
            grant_id      <= '0;
            fpu_a         <= '0;
            fpu_b         <= '0;
            fpu_op        <= '0;
            rsp_valid     <= '0;
            rsp_result    <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_any) begin
                        fpu_a    <= a_arr[win];
                        fpu_b    <= b_arr[win];
                        fpu_op   <= op_arr[win];
                        grant_id <= win;
                        cnt      <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt >= CMIN && fpu_ready) begin
                        rsp_result    <= fpu_result;
                        rsp_overflow  <= fpu_overflow;
                        rsp_underflow <= fpu_underflow;
                        rsp_timeout   <= 1'b0;
                        rsp_valid     <= NREQ'(1) << grant_id;
                        state         <= RESP;
                    end else if (cnt == CMAX) begin
                        rsp_result    <= '0;
                        rsp_overflow  <= 1'b0;
                        rsp_underflow <= 1'b0;
                        rsp_timeout   <= 1'b1;
                        rsp_valid     <= NREQ'(1) << grant_id;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (|(rsp_valid & rsp_ready)) begin
                        rsp_valid <= '0;
                        last      <= grant_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_sp_arbiter.sv
// tb_fpu_sp_arbiter: behavioural fpu_sp with settable latency,
// vector table plus corner sequences, queue scoreboard on responses.
module tb_fpu_sp_arbiter;
    import fpu_sp_pkg::*;

    localparam int W  = 32;
    localparam int N  = 2;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [N*2-1:0] req_op;
    logic [W-1:0]   rsp_result, fpu_a, fpu_b, fpu_result;
    logic           rsp_overflow, rsp_underflow, rsp_timeout;
    logic           fpu_ready, fpu_overflow, fpu_underflow, busy;
    logic [1:0]     fpu_op;
    logic [0:0]     grant_id;

    fpu_sp_arbiter #(
        .WIDTH(W), .NREQ(N), .MIN_WAIT(2), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .rsp_underflow(rsp_underflow), .rsp_timeout(rsp_timeout),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
        .fpu_result(fpu_result), .fpu_ready(fpu_ready),
        .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // fpu_sp stand-in: Ready rises L cycles after the accept edge
    int mlat = 2;
    bit mforce = 1'b0;
    bit mnever = 1'b0;
    int mcnt = 0;
    bit acc_p = 1'b0;
    int cyc = 0;

    function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        if (op == OP_ADD && a == 32'h40866666 && b == 32'h404CCCCD) return 32'h40ECCCCD;
        if (op == OP_MUL && a == 32'h42F60000 && b == 32'h43CE0000) return 32'h4745F400;
        return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    endfunction

    always @(negedge clk) acc_p <= rst_n && (|(req_valid & req_ready));
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (acc_p) mcnt <= 1;
        else if (mcnt < 1000) mcnt <= mcnt + 1;
    end

    assign fpu_ready     = mforce || (!mnever && mcnt > mlat);
    assign fpu_result    = fmodel(fpu_a, fpu_b, fpu_op);
    assign fpu_overflow  = (fpu_op == OP_MUL) && (fpu_a[30:23] >= 8'hF0);
    assign fpu_underflow = (fpu_op == OP_DIV) && (fpu_b[30:23] >= 8'hF0);

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        ovf, unf, tmo;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        int          id;
        logic [31:0] a, b;
        logic [1:0]  op;
        int          lat;
        bit          frc, nev;
        logic [31:0] res;
        logic        ovf, unf, tmo;
        int          elat;
    } vec_t;

    exp_t pend [N];
    exp_t q[$];
    int   glog[$];
    int   checks = 0;
    int   errors = 0;
    int   n_acc = 0;
    bit   seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // scoreboard: push on accept, pop and compare on response handshake
    always @(negedge clk) begin
        exp_t e;
        logic [N-1:0] acc;
        if (rst_n) begin
            acc = req_valid & req_ready;
            if (acc != '0) begin
                for (int i = 0; i < N; i++) if (acc[i]) e = pend[i];
                e.acc = cyc + 1;
                q.push_back(e);
                glog.push_back(e.id);
                n_acc++;
            end
            if (rsp_valid != '0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_rsp: got %b expected none", rsp_valid);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        if (q[0].lat > 0) chk("latency", cyc - q[0].acc, q[0].lat);
                    end
                    if ((rsp_valid & rsp_ready) != '0) begin
                        e = q.pop_front();
                        seen = 1'b0;
                        chk("rsp_valid_id", rsp_valid, N'(1) << e.id);
                        chk("rsp_result", rsp_result, e.res);
                        chk("rsp_flags", {rsp_overflow, rsp_underflow, rsp_timeout},
                            {e.ovf, e.unf, e.tmo});
                    end
                end
            end
        end
    end

    task automatic set_pend(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, input logic [31:0] res,
                            input logic ovf, input logic unf, input logic tmo, input int lat);
        pend[id] = '{id, res, ovf, unf, tmo, lat, 0};
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_op[id*2 +: 2] = op;
    endtask

    task automatic wait_acc(input int target, input string nm);
        int n = 0;
        while (n_acc < target && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk(nm, n_acc, target);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk(nm, {q.size() != 0, busy}, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int t;
        @(posedge clk); #1;
        mlat = v.lat;
        mforce = v.frc;
        mnever = v.nev;
        set_pend(v.id, v.a, v.b, v.op, v.res, v.ovf, v.unf, v.tmo, v.elat);
        t = n_acc + 1;
        req_valid[v.id] = 1'b1;
        wait_acc(t, "accept");
        @(posedge clk); #1;
        req_valid = '0;
        wait_done("done");
    endtask

    vec_t vt [8];

    initial begin : main
        int base, t, n;
        vt[0] = '{0, 32'h40866666, 32'h404CCCCD, OP_ADD, 2, 0, 0, 32'h40ECCCCD, 0, 0, 0, 3};
        vt[1] = '{1, 32'h42F60000, 32'h43CE0000, OP_MUL, 2, 0, 0, 32'h4745F400, 0, 0, 0, 3};
        vt[2] = '{0, 32'h3F800000, 32'h3F800000, OP_SUB, 4, 0, 0, 32'h3F803F81, 0, 0, 0, 5};
        vt[3] = '{1, 32'h7F000000, 32'h7F000000, OP_MUL, 3, 0, 0, 32'h7F007F02, 1, 0, 0, 4};
        vt[4] = '{0, 32'h3F800000, 32'h7F000000, OP_DIV, 5, 0, 0, 32'h3F807F03, 0, 1, 0, 6};
        vt[5] = '{1, 32'h40000000, 32'h40400000, OP_ADD, 5, 1, 0, 32'h40004040, 0, 0, 0, 3};
        vt[6] = '{0, 32'h7F000000, 32'h3F800000, OP_MUL, 2, 0, 1, 32'h00000000, 0, 0, 1, TO+1};
        vt[7] = '{1, 32'h42F60000, 32'h43CE0000, OP_MUL, 2, 0, 0, 32'h4745F400, 0, 0, 0, 3};

        req_valid = '0;
        rsp_ready = '1;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        #3;
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_grant_id", grant_id, 0);
        chk("reset_fpu", {fpu_a ^ fpu_b, 30'd0, fpu_op}, 0);
        chk("reset_rsp", {rsp_result[28:0], rsp_overflow, rsp_underflow, rsp_timeout}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // both requesters hammering: grants must alternate from requester 0
        @(posedge clk); #1;
        mlat = 2; mforce = 1'b0; mnever = 1'b0;
        set_pend(0, 32'h40866666, 32'h404CCCCD, OP_ADD, 32'h40ECCCCD, 0, 0, 0, 3);
        set_pend(1, 32'h42F60000, 32'h43CE0000, OP_MUL, 32'h4745F400, 0, 0, 0, 3);
        base = glog.size();
        t = n_acc + 4;
        req_valid = 2'b11;
        wait_acc(t, "fair_accepts");
        @(posedge clk); #1;
        req_valid = '0;
        wait_done("fair_done");
        for (int i = 0; i < 4; i++)
            if (glog.size() > base + i) chk("grant_order", glog[base+i], i % 2);

        // response back-pressure; foreign rsp_ready must be ignored
        @(posedge clk); #1;
        rsp_ready = 2'b10;
        set_pend(0, 32'h3F800000, 32'h40000000, OP_ADD, 32'h3F804000, 0, 0, 0, 3);
        set_pend(1, 32'h40000000, 32'h3F800000, OP_SUB, 32'h40003F81, 0, 0, 0, 0);
        t = n_acc + 1;
        req_valid = 2'b01;
        wait_acc(t, "hold_accept");
        @(posedge clk); #1;
        req_valid = 2'b10;
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #1;
            chk("hold_rsp_valid", rsp_valid, 2'b01);
            chk("hold_result", rsp_result, 32'h3F804000);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_busy", busy, 1);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        wait_acc(t + 1, "hold_next_accept");
        @(posedge clk); #1;
        req_valid = '0;
        wait_done("hold_done");

        run_vec(vt[0]);

        // reset during WAIT: silent abandon, pointer back to requester 0
        @(posedge clk); #1;
        mlat = 5;
        set_pend(1, 32'h40000000, 32'h40000000, OP_MUL, 32'h40004002, 0, 0, 0, 6);
        t = n_acc + 1;
        req_valid = 2'b10;
        wait_acc(t, "rst_accept");
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_fpu_op", fpu_op, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_req_ready", req_ready, 0);
        q.delete();
        seen = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mlat = 2;
        set_pend(0, 32'h40866666, 32'h404CCCCD, OP_ADD, 32'h40ECCCCD, 0, 0, 0, 3);
        set_pend(1, 32'h42F60000, 32'h43CE0000, OP_MUL, 32'h4745F400, 0, 0, 0, 3);
        t = n_acc + 2;
        req_valid = 2'b11;
        @(negedge clk); #1;
        chk("rst_rr_first", req_ready, 2'b01);
        wait_acc(t, "rst_accepts");
        @(posedge clk); #1;
        req_valid = '0;
        wait_done("rst_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
